alarm_timer_controller: RTL and testbench
=========================================

# alarm_timer_controller

Programmable delay timer for the anti-theft system: holds the four time parameters (arm delay, driver door delay, passenger door delay, alarm-on duration) and runs the single shared countdown resource. The anti-theft FSM requests a countdown with `start_timer` plus a 2-bit `interval` selector, and watches `expired`. The block also derives the one-second enable tick from the system clock. The same tick is exported for siren and status-LED blink logic.

## Interface

Parameters:
- `TICK_DIV`, 4: clock cycles per one-second tick. Use 4 in simulation; on silicon it equals the clock frequency in Hz. Minimum 2.
- `VAL_W`, 4: width of each time parameter, in seconds.
- `DEF_ARM`, 6: reset value of the arm-delay parameter.
- `DEF_DRIVER`, 8: reset value of the driver-delay parameter.
- `DEF_PASSENGER`, 15: reset value of the passenger-delay parameter.
- `DEF_ALARM`, 10: reset value of the alarm-on parameter.

Ports (one clock; reset is synchronous and active-high):
- `clock` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start_timer` input 1: load and start a countdown; single-cycle pulse or level, sampled each edge.
- `interval` input 2: parameter to load on `start_timer`. 00 = arm, 01 = driver, 10 = passenger, 11 = alarm.
- `reprogram` input 1: write `param_value` into parameter `param_sel`.
- `param_sel` input 2: same encoding as `interval`.
- `param_value` input VAL_W: new value in seconds.
- `expired` output 1: countdown finished. Held high until the next `start_timer` or `reset`.
- `busy` output 1: countdown in progress.
- `remaining` output VAL_W: seconds left in the current countdown.
- `one_hz` output 1: one-cycle tick pulse, once every TICK_DIV cycles.

## Operation

- **Parameter registers.** Four VAL_W registers, loaded with the DEF_* values on reset.
  - A write happens on any edge where `reprogram` = 1.
  - A `param_value` of 0 is stored as 1, so a zero-length countdown cannot occur.
- **Prescaler.** Counts 0 to TICK_DIV-1 and wraps.
  - `one_hz` = 1 while the count equals TICK_DIV-1.
  - The prescaler runs freely in every state.
  - It is cleared to 0 on `reset` and on every edge where `start_timer` is accepted.
- **States:** IDLE, COUNT, DONE.
  - IDLE: `busy` = 0, `expired` = 0, `remaining` = 0.
  - `start_timer` = 1 in any state: load `remaining` from parameter[`interval`], clear the prescaler, clear `expired`, go to COUNT.
  - COUNT with `one_hz` = 1 and `remaining` > 1: decrement `remaining`.
  - COUNT with `one_hz` = 1 and `remaining` = 1: set `remaining` to 0, go to DONE.
  - DONE: `expired` = 1, `busy` = 0. Stay in DONE until `start_timer` or `reset`; there is no auto-return to IDLE.
- **Restarting.** `start_timer` during COUNT aborts the current countdown and restarts with the newly selected interval.
- **Reprogram during a count.** Affects future loads only; the active `remaining` is untouched.
- **Simultaneous `reprogram` and `start_timer`, same index.** The load takes the old value and the write still happens.
- **`start_timer` takes priority** over the decrement on the same edge.
- **Reset mid-operation.** Returns to IDLE, restores all parameters to defaults, clears the prescaler. `reset` overrides all other inputs.

## Timing

- All outputs are registered, except `one_hz`, which is decoded from the prescaler register.
- Reset values: `expired` = 0, `busy` = 0, `remaining` = 0, `one_hz` = 0.
- `start_timer` sampled at edge k:
  - `busy` = 1 and `remaining` = N are visible after edge k.
  - Decrements occur at edges k+TICK_DIV, k+2·TICK_DIV, and so on.
  - `expired` rises after edge k+N·TICK_DIV.
  - Latency from start to `expired` is exactly N·TICK_DIV cycles.
- `reprogram` at edge k: the new value is visible to a `start_timer` at edge k+1 or later.
- The FSM must see `expired` fall one cycle after it pulses `start_timer`. `expired` never glitches high during COUNT.

## Structure

- The shared package `anti_theft_pkg` holds:
  - the interval encodings: `INT_ARM`, `INT_DRIVER`, `INT_PASSENGER`, `INT_ALARM`;
  - the state encoding;
  - the default time constants.
  
  The anti-theft FSM uses the same package.
- One sub-module, `one_hz_divider`: the prescaler with a synchronous clear input and the `one_hz` output.
- The parameter file and the countdown FSM live in the top module.

## Test plan

All scenarios use TICK_DIV = 4.

- **Reset.** Hold `reset` 2 cycles → `expired` = 0, `busy` = 0, `remaining` = 0. Then `start_timer` with `interval` = 00 → `remaining` = 6 and `expired` rises exactly 24 cycles later.
- **Driver delay.** `start_timer` with `interval` = 01 → `remaining` steps 8, 7, … 1, 0, one step per 4 cycles. `expired` goes high after 32 cycles and stays high 40 or more cycles until the next start.
- **Reprogram.** `reprogram` with `param_sel` = 10 and `param_value` = 3, then start with `interval` = 10 → `expired` after 12 cycles. Writing `param_value` = 0 to index 10, then starting → `expired` after 4 cycles.
- **Restart mid-count.** Start with `interval` = 11. After 10 cycles, start with `interval` = 00 → `remaining` = 6, and `expired` arrives 24 cycles after the second start.
- **Same-edge start and reprogram.** `reprogram` to index 01 with value 2 on the same edge as a start on `interval` = 01 → this countdown uses 8. The next start uses 2.
- **Reset mid-count.** Assert `reset` during a COUNT with `remaining` = 4 → IDLE, `remaining` = 0, `expired` stays 0. A reprogrammed parameter reads back its default on the next start.

Source files
------------

// File: rtl/anti_theft_pkg.sv
// Shared anti-theft definitions: interval selectors, timer state encoding and
// the default delay constants, in seconds.
package anti_theft_pkg;

  localparam logic [1:0] INT_ARM       = 2'b00;
  localparam logic [1:0] INT_DRIVER    = 2'b01;
  localparam logic [1:0] INT_PASSENGER = 2'b10;
  localparam logic [1:0] INT_ALARM     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } timer_state_e;

  localparam int ARM_DELAY_S       = 6;
  localparam int DRIVER_DELAY_S    = 8;
  localparam int PASSENGER_DELAY_S = 15;
  localparam int ALARM_ON_S        = 10;

endpackage

// File: rtl/one_hz_divider.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks,
// with a synchronous clear so a fresh countdown always starts on a full second.
module one_hz_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic one_hz
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign one_hz = (cnt_q == CNT_LAST);

endmodule

// File: rtl/alarm_timer_controller.sv
// Programmable delay timer: four delay parameters and the single shared
// one-second countdown used by the anti-theft FSM.
//
//   state    | meaning
//   ST_IDLE  | no countdown since reset; busy=0, expired=0, remaining=0
//   ST_COUNT | counting down; remaining decrements on each one_hz tick
//   ST_DONE  | countdown finished; expired held until next start or reset
module alarm_timer_controller
  import anti_theft_pkg::*;
#(
  parameter int TICK_DIV      = 4,
  parameter int VAL_W         = 4,
  parameter int DEF_ARM       = ARM_DELAY_S,
  parameter int DEF_DRIVER    = DRIVER_DELAY_S,
  parameter int DEF_PASSENGER = PASSENGER_DELAY_S,
  parameter int DEF_ALARM     = ALARM_ON_S
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [1:0]       interval,
  input  logic             reprogram,
  input  logic [1:0]       param_sel,
  input  logic [VAL_W-1:0] param_value,
  output logic             expired,
  output logic             busy,
  output logic [VAL_W-1:0] remaining,
  output logic             one_hz
);

  logic [VAL_W-1:0] param_q [4];
  timer_state_e     state_q;

  one_hz_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_divider (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_timer),
    .one_hz (one_hz)
  );

  // A stored zero would give a zero-length countdown, so it is bumped to 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      param_q[INT_ARM]       <= VAL_W'(DEF_ARM);
      param_q[INT_DRIVER]    <= VAL_W'(DEF_DRIVER);
      param_q[INT_PASSENGER] <= VAL_W'(DEF_PASSENGER);
      param_q[INT_ALARM]     <= VAL_W'(DEF_ALARM);
    end else if (reprogram) begin
      param_q[param_sel] <= (param_value == '0) ? VAL_W'(1) : param_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else if (start_timer) begin
      state_q   <= ST_COUNT;
      remaining <= param_q[interval];
      busy      <= 1'b1;
      expired   <= 1'b0;
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (one_hz) begin
            if (remaining > VAL_W'(1)) begin
              remaining <= remaining - 1'b1;
            end else begin
              remaining <= '0;
              busy      <= 1'b0;
              expired   <= 1'b1;
              state_q   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          expired <= 1'b1;
        end
        default: begin
          busy    <= 1'b0;
          expired <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_timer_controller.sv
// Directed self-checking bench for alarm_timer_controller with TICK_DIV = 4.
module tb_alarm_timer_controller;

  logic       clock;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] param_sel;
  logic [3:0] param_value;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
  logic       one_hz;

  int tests;
  int fails;

  alarm_timer_controller #(
    .TICK_DIV (4),
    .VAL_W    (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_timer (start_timer),
    .interval    (interval),
    .reprogram   (reprogram),
    .param_sel   (param_sel),
    .param_value (param_value),
    .expired     (expired),
    .busy        (busy),
    .remaining   (remaining),
    .one_hz      (one_hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] iv);
    start_timer = 1'b1;
    interval    = iv;
    step();
    start_timer = 1'b0;
  endtask

  task automatic do_reprogram(input logic [1:0] sel, input logic [3:0] val);
    reprogram   = 1'b1;
    param_sel   = sel;
    param_value = val;
    step();
    reprogram   = 1'b0;
  endtask

  // Counts edges until expired is seen; returns limit+1 on timeout.
  task automatic wait_expired(input int limit, output int cyc);
    cyc = 0;
    while (!expired && cyc <= limit) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b1;
    step();
    step();
    tests++;
    if (expired !== 1'b0 || busy !== 1'b0 || remaining !== 4'd0 || one_hz !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: exp=%b busy=%b rem=%0d hz=%b, required 0/0/0/0",
               expired, busy, remaining, one_hz);
    end
    reset = 1'b0;
    step();
    pulse_start(2'b00);
    tests++;
    if (remaining !== 4'd6 || busy !== 1'b1) begin
      fails++;
      $display("FAIL arm_load: rem=%0d busy=%b, required 6/1", remaining, busy);
    end
    step(); step(); step();
    tests++;
    if (one_hz !== 1'b1) begin
      fails++;
      $display("FAIL one_hz_phase: got %b, required 1", one_hz);
    end
    wait_expired(40, cyc);
    tests++;
    if (cyc + 3 !== 24) begin
      fails++;
      $display("FAIL arm_latency: got %0d cycles, required 24", cyc + 3);
    end
    tests++;
    if (busy !== 1'b0 || remaining !== 4'd0) begin
      fails++;
      $display("FAIL arm_done: busy=%b rem=%0d, required 0/0", busy, remaining);
    end
  endtask

  task automatic test_driver();
    int held;
    pulse_start(2'b01);
    tests++;
    if (remaining !== 4'd8) begin
      fails++;
      $display("FAIL driver_load: got %0d, required 8", remaining);
    end
    for (int j = 1; j <= 8; j++) begin
      step(); step(); step(); step();
      tests++;
      if (remaining !== 4'(8 - j) || expired !== (j == 8)) begin
        fails++;
        $display("FAIL driver_step%0d: rem=%0d exp=%b, required %0d/%b",
                 j, remaining, expired, 8 - j, (j == 8));
      end
    end
    held = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (expired === 1'b1 && busy === 1'b0) held++;
    end
    tests++;
    if (held !== 40) begin
      fails++;
      $display("FAIL driver_hold: expired held %0d cycles, required 40", held);
    end
  endtask

  task automatic test_reprogram();
    int cyc;
    do_reprogram(2'b10, 4'd3);
    pulse_start(2'b10);
    tests++;
    if (remaining !== 4'd3) begin
      fails++;
      $display("FAIL reprog_load: got %0d, required 3", remaining);
    end
    wait_expired(40, cyc);
    tests++;
    if (cyc !== 12) begin
      fails++;
      $display("FAIL reprog_latency: got %0d cycles, required 12", cyc);
    end
    do_reprogram(2'b10, 4'd0);
    pulse_start(2'b10);
    tests++;
    if (expired !== 1'b0 || remaining !== 4'd1) begin
      fails++;
      $display("FAIL zero_load: exp=%b rem=%0d, required 0/1", expired, remaining);
    end
    wait_expired(40, cyc);
    tests++;
    if (cyc !== 4) begin
      fails++;
      $display("FAIL zero_latency: got %0d cycles, required 4", cyc);
    end
  endtask

  task automatic test_restart();
    int cyc;
    pulse_start(2'b11);
    tests++;
    if (remaining !== 4'd10) begin
      fails++;
      $display("FAIL alarm_load: got %0d, required 10", remaining);
    end
    for (int i = 0; i < 9; i++) step();
    tests++;
    if (remaining !== 4'd8 || expired !== 1'b0) begin
      fails++;
      $display("FAIL alarm_midcount: rem=%0d exp=%b, required 8/0", remaining, expired);
    end
    pulse_start(2'b00);
    tests++;
    if (remaining !== 4'd6 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_load: rem=%0d busy=%b, required 6/1", remaining, busy);
    end
    wait_expired(40, cyc);
    tests++;
    if (cyc !== 24) begin
      fails++;
      $display("FAIL restart_latency: got %0d cycles, required 24", cyc);
    end
  endtask

  task automatic test_same_edge();
    int cyc;
    reprogram   = 1'b1;
    param_sel   = 2'b01;
    param_value = 4'd2;
    start_timer = 1'b1;
    interval    = 2'b01;
    step();
    reprogram   = 1'b0;
    start_timer = 1'b0;
    tests++;
    if (remaining !== 4'd8 || expired !== 1'b0) begin
      fails++;
      $display("FAIL same_edge_load: rem=%0d exp=%b, required 8/0", remaining, expired);
    end
    wait_expired(60, cyc);
    tests++;
    if (cyc !== 32) begin
      fails++;
      $display("FAIL same_edge_latency: got %0d cycles, required 32", cyc);
    end
    pulse_start(2'b01);
    tests++;
    if (remaining !== 4'd2) begin
      fails++;
      $display("FAIL new_driver_load: got %0d, required 2", remaining);
    end
    wait_expired(40, cyc);
    tests++;
    if (cyc !== 8) begin
      fails++;
      $display("FAIL new_driver_latency: got %0d cycles, required 8", cyc);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    pulse_start(2'b11);
    for (int i = 0; i < 24; i++) step();
    tests++;
    if (remaining !== 4'd4 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: rem=%0d busy=%b, required 4/1", remaining, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (remaining !== 4'd0 || busy !== 1'b0 || expired !== 1'b0 || one_hz !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: rem=%0d busy=%b exp=%b hz=%b, required 0/0/0/0",
               remaining, busy, expired, one_hz);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (expired !== 1'b0 || busy !== 1'b0 || remaining !== 4'd0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL idle_after_reset: %0d bad cycles, required 0", bad);
    end
    pulse_start(2'b10);
    tests++;
    if (remaining !== 4'd15) begin
      fails++;
      $display("FAIL passenger_default: got %0d, required 15", remaining);
    end
    pulse_start(2'b01);
    tests++;
    if (remaining !== 4'd8) begin
      fails++;
      $display("FAIL driver_default: got %0d, required 8", remaining);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset       = 1'b1;
    start_timer = 1'b0;
    interval    = 2'b00;
    reprogram   = 1'b0;
    param_sel   = 2'b00;
    param_value = 4'd0;
    test_reset();
    test_driver();
    test_reprogram();
    test_restart();
    test_same_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
